// File: rtl/forth_io_pkg.sv
// Shared definitions for the forth core I/O peripherals: register offsets,
// STATUS bit positions and the UART bit-level FSM state encoding.
package forth_io_pkg;

    typedef enum logic [2:0] {
        REG_TXDATA = 3'd0,
        REG_RXDATA = 3'd1,
        REG_STATUS = 3'd2,
        REG_DIV    = 3'd3,
        REG_CTRL   = 3'd4
    } reg_off_t;

    localparam int BIT_TX_BUSY   = 0;
    localparam int BIT_TX_HOLD   = 1;
    localparam int BIT_RX_VALID  = 2;
    localparam int BIT_RX_OVERRUN = 3;
    localparam int BIT_FRAME_ERR = 4;
    localparam int BIT_TX_DROP   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received bytes. A push while full is dropped unless a
// pop happens in the same cycle; a pop while empty is ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/forth_uart.sv
// Memory-mapped UART for the forth core data bus. Optional loopback (CTRL bit0)
// is built only when UART_LOOPBACK_EN is defined.
//   state    | meaning
//   ST_IDLE  | line idle, waiting for a byte (TX) or a falling edge (RX)
//   ST_START | start bit in progress
//   ST_DATA  | 8 data bits, LSB first
//   ST_STOP  | stop bit
module forth_uart
    import forth_io_pkg::*;
#(
    parameter logic [7:0]  BASE        = 8'hF0,
    parameter int          RX_DEPTH    = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  daddr,
    input  logic [15:0] ddata_write,
    input  logic        dwrite,
    output logic [15:0] ddata_read,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    logic [7:0]  off;
    logic        hit;
    logic        wr_tx, wr_rx, wr_st, wr_div;
    logic [15:0] div_q;
    logic        rx_overrun, frame_err, tx_drop;

    assign off    = daddr - BASE;
    assign hit    = (off < 8'd5);
    assign wr_tx  = dwrite && hit && (off[2:0] == REG_TXDATA);
    assign wr_rx  = dwrite && hit && (off[2:0] == REG_RXDATA);
    assign wr_st  = dwrite && hit && (off[2:0] == REG_STATUS);
    assign wr_div = dwrite && hit && (off[2:0] == REG_DIV);

`ifdef UART_LOOPBACK_EN
    logic loopback;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            loopback <= 1'b0;
        else if (dwrite && hit && (off[2:0] == REG_CTRL))
            loopback <= ddata_write[0];
    end
`endif

    // ---------------- TX ----------------
    uart_state_t tx_state;
    logic [7:0]  hold_q, tx_sh;
    logic        hold_full, tx_int, start_tx;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_bit;

    // The holding register feeds the shifter straight out of a finished stop bit.
    assign start_tx = hold_full &&
                      (tx_state == ST_IDLE || (tx_state == ST_STOP && tx_cnt == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state  <= ST_IDLE;
            hold_q    <= '0;
            hold_full <= 1'b0;
            tx_sh     <= '0;
            tx_cnt    <= '0;
            tx_div    <= DEFAULT_DIV;
            tx_bit    <= '0;
            tx_int    <= 1'b1;
        end else begin
            if (wr_tx && !hold_full) begin
                hold_q    <= ddata_write[7:0];
                hold_full <= 1'b1;
            end
            if (start_tx) begin
                tx_sh     <= hold_q;
                hold_full <= 1'b0;
                tx_div    <= div_q;
                tx_cnt    <= div_q - 16'd1;
                tx_int    <= 1'b0;
                tx_state  <= ST_START;
            end else if (tx_state != ST_IDLE && tx_cnt != '0) begin
                tx_cnt <= tx_cnt - 16'd1;
            end else begin
                case (tx_state)
                    ST_START: begin
                        tx_int   <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                        tx_bit   <= '0;
                        tx_cnt   <= tx_div - 16'd1;
                        tx_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        tx_cnt <= tx_div - 16'd1;
                        if (tx_bit == 3'd7) begin
                            tx_int   <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            tx_int <= tx_sh[0];
                            tx_sh  <= tx_sh >> 1;
                            tx_bit <= tx_bit + 3'd1;
                        end
                    end
                    ST_STOP: tx_state <= ST_IDLE;
                    default: tx_state <= ST_IDLE;
                endcase
            end
        end
    end

    // ---------------- RX ----------------
    uart_state_t rx_state;
    logic        rx_in, rx_meta, rx_sync, rx_prev;
    logic [15:0] rx_cnt, rx_div;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh, fifo_head;
    logic        rx_stop_smp, rx_push, frame_ev, overrun_ev, fifo_full, fifo_empty;

`ifdef UART_LOOPBACK_EN
    assign rx_in = loopback ? tx_int : rx;
    assign tx    = tx_int | loopback;
`else
    assign rx_in = rx;
    assign tx    = tx_int;
`endif

    assign rx_stop_smp = (rx_state == ST_STOP) && (rx_cnt == '0);
    assign rx_push     = rx_stop_smp && rx_sync;
    assign frame_ev    = rx_stop_smp && !rx_sync;
    assign overrun_ev  = rx_push && fifo_full && !wr_rx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DEFAULT_DIV;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (rx_state == ST_IDLE) begin
                if (rx_prev && !rx_sync) begin
                    rx_div   <= div_q;
                    rx_cnt   <= (div_q >> 1) - 16'd1;
                    rx_state <= ST_START;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 16'd1;
            end else begin
                rx_cnt <= rx_div - 16'd1;
                case (rx_state)
                    ST_START: begin
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? ST_IDLE : ST_DATA;
                    end
                    ST_DATA: begin
                        rx_sh  <= {rx_sync, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7)
                            rx_state <= ST_STOP;
                    end
                    default: rx_state <= ST_IDLE;
                endcase
            end
        end
    end

    uart_rx_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (wr_rx),
        .din   (rx_sh),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= DEFAULT_DIV;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            if (wr_div)
                div_q <= (ddata_write < 16'd2) ? 16'd2 : ddata_write;
            rx_overrun <= overrun_ev | (rx_overrun & ~(wr_st & ddata_write[BIT_RX_OVERRUN]));
            frame_err  <= frame_ev | (frame_err & ~(wr_st & ddata_write[BIT_FRAME_ERR]));
            tx_drop    <= (wr_tx & hold_full) | (tx_drop & ~(wr_st & ddata_write[BIT_TX_DROP]));
        end
    end

    logic [15:0] status;
    always_comb begin
        status                 = '0;
        status[BIT_TX_BUSY]    = (tx_state != ST_IDLE) || hold_full;
        status[BIT_TX_HOLD]    = hold_full;
        status[BIT_RX_VALID]   = !fifo_empty;
        status[BIT_RX_OVERRUN] = rx_overrun;
        status[BIT_FRAME_ERR]  = frame_err;
        status[BIT_TX_DROP]    = tx_drop;
    end

    always_comb begin
        ddata_read = '0;
        if (hit) begin
            case (off[2:0])
                REG_RXDATA: ddata_read = fifo_empty ? 16'h0 : {8'h0, fifo_head};
                REG_STATUS: ddata_read = status;
                REG_DIV:    ddata_read = div_q;
`ifdef UART_LOOPBACK_EN
                REG_CTRL:   ddata_read = {15'h0, loopback};
`endif
                default:    ddata_read = '0;
            endcase
        end
    end

    assign irq = !fifo_empty || rx_overrun || frame_err || tx_drop;

endmodule
